// File: rtl/iic_pkg.sv
// Shared constants for the I2C slave: FSM state codes and the ACK/NACK bus levels.
package iic_pkg;
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_DEVADDR   = 4'd1;
    localparam logic [3:0] ST_DEV_ACK   = 4'd2;
    localparam logic [3:0] ST_WORD      = 4'd3;
    localparam logic [3:0] ST_WORD_ACK  = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_MST_ACK   = 4'd8;
endpackage

// File: rtl/iic_filt.sv
// Bus line conditioner: 2-flop synchroniser, FILT-sample glitch filter, one-clk edge pulses.
module iic_filt #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;

    // A new level is accepted only after FILT consecutive samples disagree with the current one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILT - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
                r_fall  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/iic_slave.sv
// I2C memory slave: 7-bit device address, 8-bit word pointer with auto-increment,
// byte writes to an external memory port and sequential reads from it.
module iic_slave
    import iic_pkg::*;
#(
    parameter logic [6:0] DEV_ID = 7'h50,
    parameter int         FILT   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       wp,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic       busy
);
    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_last;
    logic [7:0] w_byte;

    logic [3:0] r_state;
    logic [6:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_ackph;
    logic       r_ackbit;
    logic       r_rw;
    logic       r_sda_oe;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_we;
    logic       r_busy;

    iic_filt #(.FILT(FILT)) u_scl (
        .clk(clk), .rst(rst), .i_line(scl_in),
        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );
    iic_filt #(.FILT(FILT)) u_sda (
        .clk(clk), .rst(rst), .i_line(sda_in),
        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;
    assign w_byte  = {r_shift, w_sda};
    assign w_last  = (r_bitcnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_ackph  <= 1'b0;
            r_ackbit <= NACK;
            r_rw     <= 1'b0;
            r_sda_oe <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                // Releasing here also recovers from a master that restarts mid-read.
                r_state  <= ST_DEVADDR;
                r_bitcnt <= '0;
                r_ackph  <= 1'b0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_scl_rise) begin
                case (r_state)
                    ST_DEVADDR, ST_WORD, ST_WDATA: begin
                        r_shift  <= w_byte[6:0];
                        r_bitcnt <= r_bitcnt + 3'd1;
                        r_ackph  <= 1'b0;
                        if (w_last) begin
                            r_bitcnt <= '0;
                            case (r_state)
                                ST_DEVADDR: begin
                                    if (w_byte[7:1] == DEV_ID) begin
                                        r_state <= ST_DEV_ACK;
                                        r_rw    <= w_byte[0];
                                        r_busy  <= 1'b1;
                                    end else begin
                                        r_state <= ST_IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                end
                                ST_WORD: begin
                                    r_addr  <= w_byte;
                                    r_state <= ST_WORD_ACK;
                                end
                                default: begin
                                    r_state  <= ST_WDATA_ACK;
                                    r_ackbit <= wp ? NACK : ACK;
                                    if (!wp) begin
                                        r_wdata <= w_byte;
                                        r_we    <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_RDATA: begin
                        if (w_last) begin
                            r_bitcnt <= '0;
                            r_addr   <= r_addr + 8'd1;
                            r_ackph  <= 1'b0;
                            r_state  <= ST_MST_ACK;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                    ST_DEV_ACK, ST_WORD_ACK, ST_WDATA_ACK: r_ackph <= 1'b1;
                    ST_MST_ACK: begin
                        r_ackph  <= 1'b1;
                        r_ackbit <= w_sda;
                    end
                    default: ;
                endcase
            end else if (w_scl_fall) begin
                // In ACK states the first fall opens the ACK slot, the second (after r_ackph) closes it.
                case (r_state)
                    ST_DEV_ACK: begin
                        if (!r_ackph) begin
                            r_sda_oe <= ~ACK;
                        end else begin
                            r_ackph  <= 1'b0;
                            r_bitcnt <= '0;
                            if (r_rw) begin
                                r_state  <= ST_RDATA;
                                r_shift  <= mem_rdata[6:0];
                                r_sda_oe <= ~mem_rdata[7];
                            end else begin
                                r_state  <= ST_WORD;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    ST_WORD_ACK: begin
                        if (!r_ackph) begin
                            r_sda_oe <= ~ACK;
                        end else begin
                            r_ackph  <= 1'b0;
                            r_bitcnt <= '0;
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_WDATA;
                        end
                    end
                    ST_WDATA_ACK: begin
                        if (!r_ackph) begin
                            r_sda_oe <= ~r_ackbit;
                        end else begin
                            r_ackph  <= 1'b0;
                            r_bitcnt <= '0;
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_WDATA;
                            if (r_ackbit == ACK) r_addr <= r_addr + 8'd1;
                        end
                    end
                    ST_RDATA: begin
                        r_sda_oe <= ~r_shift[6];
                        r_shift  <= {r_shift[5:0], 1'b0};
                    end
                    ST_MST_ACK: begin
                        if (!r_ackph) begin
                            r_sda_oe <= 1'b0;
                        end else begin
                            r_ackph  <= 1'b0;
                            r_bitcnt <= '0;
                            if (r_ackbit == ACK) begin
                                r_state  <= ST_RDATA;
                                r_shift  <= mem_rdata[6:0];
                                r_sda_oe <= ~mem_rdata[7];
                            end else begin
                                r_state  <= ST_IDLE;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    default: r_sda_oe <= 1'b0;
                endcase
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign busy      = r_busy;
endmodule

// File: tb/tb_iic_slave.sv
// Bit-banged I2C master driving iic_slave against a memory/pointer reference model.
module tb_iic_slave;
    import iic_pkg::*;

    localparam logic [6:0] DEV = 7'h50;
    localparam int         Q   = 10;

    logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1, wp = 1'b0, mem_init = 1'b1;
    logic sda_in, sda_oe, mem_we, busy;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    iic_slave #(.DEV_ID(DEV), .FILT(3)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_in), .sda_oe(sda_oe), .wp(wp),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    assign sda_in = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [7:0]  exp_mem [256];
    logic [15:0] wq[$];
    logic [15:0] ewq[$];
    logic [7:0]  wdq[$];
    logic [7:0]  m_ptr = 8'h00;
    int          oe_cnt = 0;
    int          errs = 0, checks = 0;

    function automatic logic [7:0] pat(int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    always @(posedge clk) begin
        if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bit_wr(input logic b, input logic glitch);
        sda_m = b; clks(Q);
        if (glitch) begin scl_m = 1'b1; clks(2); scl_m = 1'b0; clks(Q); end
        scl_m = 1'b1; clks(2 * Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic bit_rd(output logic b);
        sda_m = 1'b1; clks(Q);
        scl_m = 1'b1; clks(Q);
        b = sda_in; clks(Q);
        scl_m = 1'b0; clks(Q);
    endtask

    task automatic start();
        sda_m = 1'b1; clks(Q); scl_m = 1'b1; clks(Q);
        sda_m = 1'b0; clks(Q); scl_m = 1'b0; clks(Q);
    endtask

    task automatic stop();
        sda_m = 1'b0; clks(Q); scl_m = 1'b1; clks(Q); sda_m = 1'b1; clks(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic a, input int gl);
        for (int i = 7; i >= 0; i--) bit_wr(d[i], (i == gl));
        bit_rd(a);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic mack);
        for (int i = 7; i >= 0; i--) bit_rd(d[i]);
        bit_wr(mack, 1'b0);
    endtask

    task automatic chk_writes();
        chk("n_writes", wq.size(), ewq.size());
        while (wq.size() > 0 && ewq.size() > 0) chk("write", wq.pop_front(), ewq.pop_front());
        wq.delete(); ewq.delete();
    endtask

    // Writes all bytes queued in wdq starting at ptr; gl puts an SCL glitch into the first data byte.
    task automatic do_write(input logic [7:0] ptr, input logic wpv, input int gl);
        logic a;
        logic [7:0] d;
        int n;
        n = wdq.size();
        wp = wpv;
        start();
        wr_byte({DEV, 1'b0}, a, -1); chk("dev_ack", a, ACK); chk("busy", busy, 1'b1);
        wr_byte(ptr, a, -1);         chk("word_ack", a, ACK);
        for (int i = 0; i < n; i++) begin
            d = wdq.pop_front();
            wr_byte(d, a, (i == 0) ? gl : -1);
            chk("data_ack", a, wpv ? NACK : ACK);
            if (!wpv) begin
                ewq.push_back({8'(ptr + i), d});
                exp_mem[8'(ptr + i)] = d;
            end
        end
        stop();
        wp = 1'b0;
        m_ptr = wpv ? ptr : 8'(ptr + n);
        chk("busy_stop", busy, 1'b0);
        chk("wr_ptr", mem_addr, m_ptr);
        chk_writes();
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n);
        logic a;
        logic [7:0] d;
        start();
        wr_byte({DEV, 1'b0}, a, -1); chk("rd_dev_ack", a, ACK);
        wr_byte(ptr, a, -1);         chk("rd_word_ack", a, ACK);
        start();
        wr_byte({DEV, 1'b1}, a, -1); chk("rd_dev1_ack", a, ACK);
        for (int i = 0; i < n; i++) begin
            rd_byte(d, (i == n - 1) ? NACK : ACK);
            chk("rdata", d, exp_mem[8'(ptr + i)]);
        end
        clks(2);
        chk("rd_release", sda_oe, 1'b0);
        stop();
        m_ptr = 8'(ptr + n);
        chk("rd_ptr", mem_addr, m_ptr);
        chk_writes();
    endtask

    task automatic mismatch(input logic [6:0] dv);
        logic a;
        int oe0;
        oe0 = oe_cnt;
        start();
        wr_byte({dv, 1'b0}, a, -1); chk("mis_ack", a, NACK); chk("mis_busy", busy, 1'b0);
        wr_byte({DEV, 1'b0}, a, -1); chk("mis_ack2", a, NACK);
        stop();
        chk("mis_oe", oe_cnt - oe0, 0);
        chk("mis_ptr", mem_addr, m_ptr);
        chk_writes();
    endtask

    initial begin
        logic a;
        logic [6:0] dv;
        logic [7:0] ptr;
        int n;
        for (int i = 0; i < 256; i++) exp_mem[i] = pat(i);
        clks(4);
        chk("rst_oe", sda_oe, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_wdata", mem_wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0; mem_init = 1'b0;
        clks(5);

        wdq = '{8'h5A, 8'hC3};  do_write(8'h10, 1'b0, -1);
        do_read(8'h10, 2);
        mismatch(7'h51);
        wdq = '{8'h11};         do_write(8'h20, 1'b1, -1);
        wdq = '{8'h3E, 8'h7B};  do_write(8'hFF, 1'b0, -1);
        do_read(8'hFE, 3);
        wdq = '{8'h96, 8'h3C};  do_write(8'h40, 1'b0, 3);
        do_read(8'h40, 2);

        // Reset while the slave is driving a read bit low.
        wdq = '{8'h00};         do_write(8'h30, 1'b0, -1);
        start();
        wr_byte({DEV, 1'b0}, a, -1);
        wr_byte(8'h30, a, -1);
        start();
        wr_byte({DEV, 1'b1}, a, -1);
        clks(2);
        chk("rdata_drive", sda_oe, 1'b1);
        rst = 1'b1; clks(1);
        chk("midrst_oe", sda_oe, 1'b0);
        chk("midrst_addr", mem_addr, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        rst = 1'b0; m_ptr = 8'h00;
        clks(4);
        stop();
        do_read(8'h30, 1);

        for (int it = 0; it < 6; it++) begin
            ptr = ($urandom_range(0, 2) == 0) ? 8'hFE : 8'($urandom);
            n = $urandom_range(1, 3);
            case ($urandom_range(0, 3))
                0, 1: begin
                    for (int k = 0; k < n; k++) wdq.push_back(8'($urandom));
                    do_write(ptr, ($urandom_range(0, 3) == 0), -1);
                end
                2: do_read(ptr, n);
                default: begin
                    dv = 7'($urandom);
                    if (dv == DEV) dv = DEV ^ 7'h01;
                    mismatch(dv);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
